// File: rtl/m_imem_loader_pkg.sv
// Shared constants, state encoding and length check for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package m_imem_loader_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } ldr_state_t;

    // A load must name between one word and the full memory.
    function automatic logic len_is_valid(input logic [LEN_W-1:0] len, input int depth);
        return (len != '0) && ({1'b0, len} <= 8'(depth));
    endfunction

endpackage

// File: rtl/m_imem_loader_if.sv
// Byte-stream handshake feeding the loader.
// Latency: n/a (wiring only).
// Backpressure: source holds w_rx_data while w_rx_valid is high and w_rx_ready is low.
interface m_imem_loader_if;
    import m_imem_loader_pkg::*;

    logic              w_rx_valid;
    logic [BYTE_W-1:0] w_rx_data;
    logic              w_rx_ready;

    modport master (
        output w_rx_valid,
        output w_rx_data,
        input  w_rx_ready
    );

    modport slave (
        input  w_rx_valid,
        input  w_rx_data,
        output w_rx_ready
    );

endinterface

// File: rtl/m_imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; strobes on the fourth byte.
// Latency: word and strobe are combinational with the fourth byte's accept.
// Backpressure: none; the caller only presents accepted bytes.
module m_byte_packer
    import m_imem_loader_pkg::*;
(
    input  logic              w_clock,
    input  logic              w_reset_n,
    input  logic              w_clear,
    input  logic              w_byte_vld,
    input  logic [BYTE_W-1:0] w_byte_dat,
    output logic              w_word_stb,
    output logic [WORD_W-1:0] w_word_dat
);

    logic [1:0]               byte_cnt;
    logic [WORD_W-BYTE_W-1:0] shift_q;

    // Newest byte enters at the top, so byte 0 lands in [7:0] after four shifts.
    assign w_word_dat = {w_byte_dat, shift_q};
    assign w_word_stb = w_byte_vld && (byte_cnt == 2'd3);

    always_ff @(posedge w_clock) begin
        if (!w_reset_n) begin
            byte_cnt <= 2'd0;
            shift_q  <= '0;
        end else if (w_clear) begin
            byte_cnt <= 2'd0;
        end else if (w_byte_vld) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift_q  <= w_word_dat[WORD_W-1:BYTE_W];
        end
    end

endmodule

// File: rtl/m_imem_loader.sv
// Loads a program from a byte stream into instruction memory, then releases the CPU.
// Latency: word written on its fourth byte's edge; fetch path is combinational.
// Backpressure: w_rx_ready is high only while loading; bytes are accepted every cycle then.
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int DEPTH  = m_imem_loader_pkg::DEPTH,
    parameter int ADDR_W = m_imem_loader_pkg::ADDR_W
)(
    input  logic              w_clock,
    input  logic              w_reset_n,
    input  logic              w_start,
    input  logic [LEN_W-1:0]  w_len,
    m_imem_loader_if.slave    rx,
    input  logic [31:0]       w_pc,
    output logic [WORD_W-1:0] w_insn,
    output logic              w_cpu_run,
    output logic              w_busy,
    output logic              w_done,
    output logic              w_err
);

    ldr_state_t        state;
    logic [ADDR_W-1:0] word_addr;
    logic [LEN_W-1:0]  word_cnt;
    logic [LEN_W-1:0]  len_q;
    logic              rx_rdy_q;
    logic              cpu_run_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              start_ok;
    logic              byte_acc;
    logic              word_stb;
    logic [WORD_W-1:0] word_dat;
    logic              last_word;
    logic              unused_pc;

    // Contents start at zero and survive reset; only loads change them.
    logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

    assign start_ok  = w_start && (state != ST_LOAD) && len_is_valid(w_len, DEPTH);
    assign byte_acc  = rx.w_rx_valid && rx_rdy_q;
    assign last_word = (word_cnt + LEN_W'(1)) == len_q;

    assign rx.w_rx_ready = rx_rdy_q;
    assign w_cpu_run     = cpu_run_q;
    assign w_busy        = busy_q;
    assign w_done        = done_q;
    assign w_err         = err_q;

    m_byte_packer u_packer (
        .w_clock    (w_clock),
        .w_reset_n  (w_reset_n),
        .w_clear    (start_ok),
        .w_byte_vld (byte_acc),
        .w_byte_dat (rx.w_rx_data),
        .w_word_stb (word_stb),
        .w_word_dat (word_dat)
    );

    always_ff @(posedge w_clock) begin
        if (!w_reset_n) begin
            state     <= ST_IDLE;
            word_addr <= '0;
            word_cnt  <= '0;
            len_q     <= '0;
            rx_rdy_q  <= 1'b0;
            cpu_run_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (start_ok) begin
                        state     <= ST_LOAD;
                        word_addr <= '0;
                        word_cnt  <= '0;
                        len_q     <= w_len;
                        err_q     <= 1'b0;
                        rx_rdy_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        cpu_run_q <= 1'b0;
                    end else if (w_start) begin
                        err_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (word_stb) begin
                        word_addr <= word_addr + ADDR_W'(1);
                        word_cnt  <= word_cnt + LEN_W'(1);
                        if (last_word) begin
                            state     <= ST_RUN;
                            rx_rdy_q  <= 1'b0;
                            busy_q    <= 1'b0;
                            cpu_run_q <= 1'b1;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rx_rdy_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    cpu_run_q <= 1'b0;
                end
            endcase
        end
    end

    // Gated by reset so a byte landing on a reset edge cannot commit a word.
    always_ff @(posedge w_clock) begin
        if (w_reset_n && word_stb) begin
            mem[word_addr] <= word_dat;
        end
    end

    assign w_insn    = mem[w_pc[ADDR_W+1:2]];
    assign unused_pc = ^{w_pc[31:ADDR_W+2], w_pc[1:0]};

endmodule
